// File: rtl/multicyc_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One multiplier/quotient bit per cycle; start/busy/done handshake.
module multicyc_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt;
  logic                   is_div, neg_res, sign_a;
  logic [WIDTH-1:0]       opnd;
  logic [2*WIDTH-1:0]     acc;

  // request decode
  logic                   accept, is_md, op_div, op_sgn, sa, sb, b_zero;
  logic [WIDTH-1:0]       mag_a, mag_b;

  always_comb begin
    is_md  = ~op[2];
    op_div = op[1];
    op_sgn = ~op[0];
    accept = start && (state == IDLE) && !(op[2] && op[1]);
    sa     = is_md && op_sgn && src_a[WIDTH-1];
    sb     = is_md && op_sgn && src_b[WIDTH-1];
    mag_a  = sa ? -src_a : src_a;
    mag_b  = sb ? -src_b : src_b;
    b_zero = (src_b == '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (!is_md || (op_div && b_zero)) ? DONE : RUN;
      RUN:  if (cnt == CW'(WIDTH-1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // acc = {upper, lower}: multiply keeps the multiplier in the lower half and
  // shifts the product in from the top; divide keeps {remainder, dividend/quotient}.
  logic [WIDTH:0]         mul_sum, div_sh, div_tr;
  logic [2*WIDTH-1:0]     step_acc, prod_fix;
  logic [WIDTH-1:0]       quo_fix, rem_fix;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // remainder < divisor keeps the trial below 2^WIDTH when non-negative,
    // so bit WIDTH is a reliable borrow flag
    div_tr  = div_sh - {1'b0, opnd};
    if (!is_div)
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    else if (div_tr[WIDTH])
      step_acc = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      step_acc = {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      sign_a      <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          div_by_zero <= is_md && op_div && b_zero;
          cnt         <= '0;
          is_div      <= op_div;
          neg_res     <= sa ^ sb;
          sign_a      <= sa;
          if (!is_md) begin
            if (op[0]) lo <= src_a;
            else       hi <= src_a;
          end else if (op_div && b_zero) begin
            hi <= src_a;
            lo <= '1;
          end else if (op_div) begin
            opnd <= mag_b;
            acc  <= {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd <= mag_a;
            acc  <= {{WIDTH{1'b0}}, mag_b};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= step_acc;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_multicyc_muldiv.sv
// Scoreboard bench: stimulus pushes expected hi/lo/flag/done-cycle, a monitor pops on done.
module tb_multicyc_muldiv;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0, checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  multicyc_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"},    64'(hi), 64'(e.hi));
        chk({e.name, "_lo"},    64'(lo), 64'(e.lo));
        chk({e.name, "_dbz"},   64'(div_by_zero), 64'(e.dbz));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; p1/p2 are cycles (relative to accept) in which a
  // stray MULT start is pulsed while the op is in flight (0 = none).
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edbz, input int lat, input int p1, input int p2);
    int c;
    sb.push_back('{eh, el, edbz, cyc + lat, nm});
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (busy && c < 200) begin
      start = (c == p1) || (c == p2);
      if (start) begin op = 3'd0; src_a = 32'd5; src_b = 32'd9; end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(c - 1), 64'(lat));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);
    chk("reset_dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg",    3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 0, 0);
    run_op("multu_max",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0, 0);
    run_op("divu_100_7",  3'b011, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 34, 0, 0);
    run_op("div_m7_2",    3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0, 0);
    run_op("div_7_m2",    3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 34, 0, 0);
    run_op("div_minneg",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 34, 0, 0);
    run_op("div_by_zero", 3'b010, 32'd42,        32'd0,        32'd42,        32'hFFFF_FFFF, 1'b1, 1,  0, 0);
    run_op("mtlo",        3'b101, 32'd7,         32'd99,       32'd42,        32'd7,         1'b0, 1,  0, 0);
    run_op("mthi",        3'b100, 32'h1234,      32'd99,       32'h1234,      32'd7,         1'b0, 1,  0, 0);

    op = 3'b110; src_a = 32'hDEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reserved_busy", 64'(busy), 64'd0);
    chk("reserved_hi",   64'(hi),   64'h1234);
    @(negedge clk);
    chk("reserved_done", 64'(done), 64'd0);

    run_op("divu_ignore", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 5, 34);

    op = 3'b000; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midop_hi_held", 64'(hi), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    repeat (3) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);

    run_op("multu_3_4", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
